// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// master = controller side, slave = datapath side.
interface mips_mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       irwrite;
  logic       pcwrite;
  logic       branch;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic [1:0] memtoreg;
  logic [1:0] regdst;
  logic       err;
  logic [3:0] state_o;

  modport master (
    input  opcode, funct, mem_ready,
    output irwrite, pcwrite, branch, iord, memread, memwrite, regwrite,
           alusrca, alusrcb, aluop, pcsrc, memtoreg, regdst, err, state_o
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  irwrite, pcwrite, branch, iord, memread, memwrite, regwrite,
           alusrca, alusrcb, aluop, pcsrc, memtoreg, regdst, err, state_o
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared datapath for RTYPE/LW/SW/
// BEQ/ADDI/J/JAL/JR, with a mem_ready watchdog that traps into a sticky ERROR.
module mips_mc_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  mips_mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13,
    S_ERROR   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_e        state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          mem_wait;
  logic          timed_out;

  logic       irwrite_c, pcwrite_c, branch_c, iord_c, memread_c;
  logic       memwrite_c, regwrite_c, alusrca_c;
  logic [1:0] alusrcb_c, aluop_c, pcsrc_c, memtoreg_c, regdst_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mem_wait  = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                     (state_q == S_MEMWR);
  // mem_ready on the TIMEOUT cycle still completes the access.
  assign timed_out = mem_wait && !bus.mem_ready && (tmo_q == CW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = (bus.funct == FN_JR) ? S_JR : S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR:  state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_JAL:     state_d = S_FETCH;
      S_JR:      state_d = S_FETCH;
      S_ERROR:   state_d = S_ERROR;
      default:   state_d = S_ERROR;
    endcase
    if (timed_out) state_d = S_ERROR;
  end

  // Any state change restarts the watchdog, so each wait state sees a fresh count.
  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q)
      tmo_d = '0;
    else if (mem_wait && !bus.mem_ready)
      tmo_d = tmo_q + 1'b1;
  end

  always_comb begin
    irwrite_c  = 1'b0;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    iord_c     = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    aluop_c    = 2'b00;
    pcsrc_c    = 2'b00;
    memtoreg_c = 2'b00;
    regdst_c   = 2'b00;
    case (state_q)
      S_FETCH: begin
        memread_c = 1'b1;
        alusrcb_c = 2'b01;
        irwrite_c = bus.mem_ready;
        pcwrite_c = bus.mem_ready;
      end
      S_DECODE: alusrcb_c = 2'b11;
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
      end
      S_MEMRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 2'b01;
      end
      S_MEMWR: begin
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
      end
      S_EXECUTE: begin
        alusrca_c = 1'b1;
        aluop_c   = 2'b10;
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        regdst_c   = 2'b01;
      end
      S_BRANCH: begin
        alusrca_c = 1'b1;
        aluop_c   = 2'b01;
        branch_c  = 1'b1;
        pcsrc_c   = 2'b01;
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
      end
      S_ADDIWB: regwrite_c = 1'b1;
      S_JUMP: begin
        pcwrite_c = 1'b1;
        pcsrc_c   = 2'b10;
      end
      S_JAL: begin
        regwrite_c = 1'b1;
        regdst_c   = 2'b10;
        memtoreg_c = 2'b10;
        pcwrite_c  = 1'b1;
        pcsrc_c    = 2'b10;
      end
      S_JR: begin
        pcwrite_c = 1'b1;
        pcsrc_c   = 2'b11;
      end
      default: ;
    endcase
  end

  // Write enables are masked while reset is held so an aborted instruction
  // cannot commit anything, even though FETCH's Mealy term follows mem_ready.
  assign bus.irwrite  = irwrite_c  & reset_n;
  assign bus.pcwrite  = pcwrite_c  & reset_n;
  assign bus.branch   = branch_c   & reset_n;
  assign bus.memwrite = memwrite_c & reset_n;
  assign bus.regwrite = regwrite_c & reset_n;
  assign bus.iord     = iord_c;
  assign bus.memread  = memread_c;
  assign bus.alusrca  = alusrca_c;
  assign bus.alusrcb  = alusrcb_c;
  assign bus.aluop    = aluop_c;
  assign bus.pcsrc    = pcsrc_c;
  assign bus.memtoreg = memtoreg_c;
  assign bus.regdst   = regdst_c;
  assign bus.err      = (state_q == S_ERROR);
  assign bus.state_o  = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized bench for mips_mc_ctrl: per-instruction expected state/control
// traces are built from the instruction semantics and compared each cycle.
module tb_mips_mc_ctrl;
  localparam int TMO = 15;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl #(.TIMEOUT(TMO), .CW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int q_st[$];
  bit q_mr[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Control word per state from the instruction-step table.
  function automatic logic [18:0] exp_ctrl(input int st, input bit mr);
    logic ir, pw, br, iord, mrd, mw, rw, asa, e;
    logic [1:0] asb, aop, psrc, m2r, rd;
    {ir, pw, br, iord, mrd, mw, rw, asa, e} = '0;
    {asb, aop, psrc, m2r, rd} = '0;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; ir = mr; pw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; aop = 2'b01; br = 1; psrc = 2'b01; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pw = 1; psrc = 2'b10; end
      12: begin rw = 1; rd = 2'b10; m2r = 2'b10; pw = 1; psrc = 2'b10; end
      13: begin pw = 1; psrc = 2'b11; end
      15: e = 1;
      default: ;
    endcase
    return {ir, pw, br, iord, mrd, mw, rw, asa, asb, aop, psrc, m2r, rd, e};
  endfunction

  function automatic logic [18:0] obs_ctrl();
    return {bus.irwrite, bus.pcwrite, bus.branch, bus.iord, bus.memread,
            bus.memwrite, bus.regwrite, bus.alusrca, bus.alusrcb, bus.aluop,
            bus.pcsrc, bus.memtoreg, bus.regdst, bus.err};
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input int st, input bit mr);
    q_st.push_back(st);
    q_mr.push_back(mr);
  endfunction

  // Error: stay in ERROR for 20 cycles whatever mem_ready does.
  function automatic void push_error();
    for (int i = 0; i < 20; i++) push(15, rbit());
  endfunction

  // A memory state waits w cycles; more than TMO idle cycles traps to ERROR.
  function automatic bit push_mem(input int st, input int w);
    if (w > TMO) begin
      for (int i = 0; i <= TMO; i++) push(st, 1'b0);
      push_error();
      return 1'b1;
    end
    for (int i = 0; i < w; i++) push(st, 1'b0);
    push(st, 1'b1);
    return 1'b0;
  endfunction

  function automatic bit build(input logic [5:0] op, input logic [5:0] fn,
                               input int wf, input int wm);
    q_st.delete();
    q_mr.delete();
    if (push_mem(0, wf)) return 1'b1;
    push(1, rbit());
    case (op)
      6'b100011: begin push(2, rbit()); if (push_mem(3, wm)) return 1'b1; push(4, rbit()); end
      6'b101011: begin push(2, rbit()); if (push_mem(5, wm)) return 1'b1; end
      6'b000000: if (fn == 6'b001000) push(13, rbit());
                 else begin push(6, rbit()); push(7, rbit()); end
      6'b000100: push(8, rbit());
      6'b001000: begin push(9, rbit()); push(10, rbit()); end
      6'b000010: push(11, rbit());
      6'b000011: push(12, rbit());
      default: begin push_error(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  task automatic do_reset();
    bus.mem_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(0, 1'b0)));
    @(negedge clk);
    #1;
    check("rst_hold_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(0, 1'b0)));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int wf,
                     input int wm, input int max_steps);
    bit dead;
    dead = build(op, fn, wf, wm);
    for (int i = 0; i < q_st.size() && i < max_steps; i++) begin
      bus.mem_ready = q_mr[i];
      bus.opcode    = (q_st[i] == 0) ? 6'($urandom) : op;
      bus.funct     = (q_st[i] == 0) ? 6'($urandom) : fn;
      #1;
      check($sformatf("op%02h_step%0d_state", op, i), 32'(bus.state_o), 32'(q_st[i]));
      check($sformatf("op%02h_step%0d_ctrl", op, i), 32'(obs_ctrl()),
            32'(exp_ctrl(q_st[i], q_mr[i])));
      @(negedge clk);
    end
    if (dead) do_reset();
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b001000, 6'b000010, 6'b000011};
  endfunction

  initial begin
    logic [5:0] ops [9];
    logic [5:0] op, fn;
    int k, wf, wm;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100,
            6'b001000, 6'b000010, 6'b000011, 6'b111111};
    bus.opcode = '0;
    bus.funct = '0;
    bus.mem_ready = 1'b0;
    do_reset();

    run(6'b100011, 6'b000000, 0, 0, 1000);   // LW, no waits
    run(6'b101011, 6'b010101, 0, 3, 1000);   // SW, 3 wait cycles in MEMWR
    run(6'b000000, 6'b001000, 0, 0, 1000);   // JR
    run(6'b000000, 6'b100000, 0, 0, 1000);   // ADD
    run(6'b000011, 6'b000000, 0, 0, 1000);   // JAL
    run(6'b111111, 6'b000000, 0, 0, 1000);   // illegal -> ERROR, then reset
    run(6'b000010, 6'b000000, TMO + 1, 0, 1000); // FETCH timeout
    run(6'b000010, 6'b000000, TMO, 0, 1000);     // ready on the boundary cycle
    run(6'b100011, 6'b000000, 0, TMO, 1000);     // MEMRD boundary
    run(6'b101011, 6'b000000, 0, TMO + 1, 1000); // MEMWR timeout
    run(6'b100011, 6'b000000, 0, 5, 5);          // abort mid-MEMRD
    do_reset();

    for (int n = 0; n < 120; n++) begin
      k  = $urandom_range(0, 8);
      op = ops[k];
      fn = 6'($urandom);
      if (k == 2) fn = 6'b001000;
      if (k == 3 && fn == 6'b001000) fn = 6'b100000;
      if (k == 8) begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end
      wf = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 1, TMO + 2) : $urandom_range(0, 3);
      wm = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 1, TMO + 2) : $urandom_range(0, 3);
      run(op, fn, wf, wm, 1000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Moore/Mealy control FSM that sequences the shared multicycle MIPS datapath (one memory, one ALU, register file, IR/PC registers).
- Implements RTYPE, LW, SW, BEQ, ADDI, J, JAL and JR.
- Uses a memory ready handshake with a timeout watchdog.
- Sits beside the datapath and drives every enable and mux select in it.

Parameters:
- TIMEOUT, 15, maximum cycles to wait for mem_ready in any memory state before entering ERROR (1..255).
- CW, 8, width of the timeout counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current access this cycle
- irwrite  out  1  load IR
- pcwrite  out  1  unconditional PC load
- branch  out  1  PC load if ALU zero
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- regwrite  out  1  register file write
- alusrca  out  1  0 = PC, 1 = rs
- alusrcb  out  2  00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2
- aluop  out  2  00 add, 01 sub, 10 use funct
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs (JR)
- memtoreg  out  2  00 ALUOut, 01 MDR, 10 PC (link)
- regdst  out  2  00 rt, 01 rd, 10 $31
- err  out  1  sticky error flag
- state_o  out  4  current state encoding, for debug

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010, JAL 000011. JR is RTYPE with funct 001000.
- Reset (async, reset_n=0): state=FETCH, timeout count=0, err=0. All enables 0; all selects 0 except alusrcb=01 (FETCH defaults). Reset mid-instruction aborts it immediately, and no further enable is asserted.
- Defaults in every state: all enables 0 and all selects 00 unless listed below.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite=pcwrite=mem_ready (Mealy). Goes to DECODE when mem_ready=1; otherwise stays.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by opcode:
  - LW/SW -> MEMADR
  - RTYPE with funct 001000 -> JR
  - other RTYPE -> EXECUTE
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - JAL -> JAL
  - any other opcode -> ERROR
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD (LW) or MEMWR (SW).
- MEMRD: memread=1, iord=1. Goes to MEMWB on mem_ready.
- MEMWB: regwrite=1, regdst=00, memtoreg=01. Goes to FETCH.
- MEMWR: memwrite=1, iord=1; both held until mem_ready. Goes to FETCH on mem_ready.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Goes to ALUWB.
- ALUWB: regwrite=1, regdst=01, memtoreg=00. Goes to FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01. Goes to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Goes to ADDIWB.
- ADDIWB: regwrite=1, regdst=00, memtoreg=00. Goes to FETCH.
- JUMP: pcwrite=1, pcsrc=10. Goes to FETCH.
- JAL: regwrite=1, regdst=10, memtoreg=10, pcwrite=1, pcsrc=10, in one cycle. PC still holds PC+4, so $31 receives the return address. Goes to FETCH.
- JR: pcwrite=1, pcsrc=11. Goes to FETCH.
- Timeout watchdog:
  - Counter clears on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle those states are held with mem_ready=0.
  - When the count reaches TIMEOUT with mem_ready still 0, the next state is ERROR.
  - A mem_ready on the same cycle the count hits TIMEOUT wins: the access completes normally.
- ERROR: err=1, all enables 0. Stays there until reset_n is asserted.
- Latencies assuming mem_ready is high on first request:
  - J, JAL, JR, BEQ: 3 cycles
  - RTYPE, ADDI, SW: 4 cycles
  - LW: 5 cycles
- Each cycle of mem_ready=0 wait adds one cycle.
- Encoding for state_o: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, JAL=12, JR=13, ERROR=15.

Test Plan:
- Reset release, then opcode=100011 (LW) with mem_ready=1 throughout -> states 0,1,2,3,4,0. regwrite=1 only in state 4, with memtoreg=01 and regdst=00.
- SW with mem_ready low for 3 cycles in MEMWR -> memwrite=1, iord=1 held for 4 cycles. Returns to FETCH after mem_ready=1; err=0.
- RTYPE funct=001000 -> sequence FETCH, DECODE, JR with pcwrite=1, pcsrc=11 and regwrite=0. RTYPE funct=100000 -> EXECUTE, then ALUWB with regdst=01.
- JAL opcode 000011 -> a single JAL-state cycle with regwrite=1, regdst=10, memtoreg=10, pcwrite=1, pcsrc=10.
- Illegal opcode 111111 -> ERROR (state_o=15), err=1 held through 20 cycles, no enables asserted. reset_n pulse -> FETCH, err=0.
- FETCH with mem_ready=0 for 16 cycles (TIMEOUT=15) -> ERROR. Repeat with mem_ready=1 on the 16th cycle -> DECODE, no error. Assert reset_n=0 mid-MEMRD -> immediately FETCH, memread=1, irwrite=0.
